mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//   Owns the single 8-bit memory bus and shares it between the fetch and exec
//   stages. It replaces the inline request muxing in the core top level.
//   Provides a transaction lock, exec-first priority with a fetch
//   anti-starvation limit, a registered read-data capture, and an optional
//   watchdog on the memory handshake.
// PARAMETERS
//   ADDR_W        8   address width
//   DATA_W        8   data width
//   STARVE_LIMIT  4   consecutive exec grants allowed while f_req waits; 0 = pure exec priority
//   TIMEOUT       64  cycles in a grant state without mem_ready before abort; 0 = no watchdog
// PORTS
//   clk        in   1       clock
//   rst        in   1       asynchronous reset, active-high
//   f_req      in   1       fetch request; held with f_addr until f_ready
//   f_addr     in   ADDR_W  fetch read address
//   f_ready    out  1       one-cycle pulse: fetch transaction done, rdata valid
//   e_req      in   1       exec request; held with e_addr/e_we/e_wdata until e_ready
//   e_we       in   1       exec write enable
//   e_addr     in   ADDR_W  exec address
//   e_wdata    in   DATA_W  exec write data
//   e_ready    out  1       one-cycle pulse: exec transaction done (rdata valid if read)
//   rdata      out  DATA_W  read data captured at completion; held until the next completion
//   grant      out  2       one-hot owner {exec,fetch}; drives the external data-bus tristate
//   mem_req    out  1       memory request
//   mem_we     out  1       memory write enable; asserted only while mem_req=1
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data; valid when mem_ready=1
//   mem_ready  in   1       memory completion; sampled only in grant states
//   timeout    out  1       one-cycle pulse on watchdog abort
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 (mem_*, grant, rdata, ready pulses,
//     timeout); starve and watchdog counters 0. Reset is asynchronous, so it
//     clears mem_req immediately, including mid-transaction.
//   States: IDLE, GNT_F, GNT_E, DONE. All outputs are registered.
//   IDLE: arbitrate on the requests sampled at the edge.
//     - e_req && (!f_req || starve<STARVE_LIMIT || STARVE_LIMIT==0) -> GNT_E.
//     - Otherwise, if f_req -> GNT_F.
//     - Otherwise stay in IDLE.
//     - On grant, latch the owner's addr/we/wdata into mem_*, set mem_req=1,
//       and set the grant bit at the same edge.
//       Latency: request visible at edge k -> mem_req=1 from edge k.
//   GNT_x: hold mem_* constant. Changes on the requester inputs are ignored.
//     - mem_ready=1 at an edge: rdata<=mem_rdata (reads only), mem_req<=0,
//       mem_we<=0, the owner's ready pulse <=1, go to DONE.
//     - Watchdog: count cycles in GNT_x. When count reaches TIMEOUT: mem_req<=0,
//       timeout pulse, owner ready pulse, rdata unchanged, go to DONE.
//     - If the owner drops req early, the transaction still runs to mem_ready
//       or timeout. Memory cycles are never cancelled.
//   DONE: one cycle. mem_req=0 (bus turnaround), ready pulse high, grant held.
//     - Next state is IDLE; grant clears.
//     - Requests are not sampled in DONE. The owner drops req, or presents a
//       new request, at the edge where it sees ready.
//   Back-to-back minimum: 4 cycles per transaction with a 1-cycle memory.
//   Starve counter (width clog2(STARVE_LIMIT+1)):
//     - +1 on each GNT_E entry while f_req=1, saturating.
//     - Cleared on each GNT_F entry, and on a GNT_E entry with f_req=0.
//   Simultaneous requests: exec wins unless the starve limit is reached.
//     Exec priority prevents deadlock, because exec blocks the pipeline.
//   Invariants:
//     - grant is one-hot or zero.
//     - f_ready and e_ready are never high together.
//     - mem_we=1 implies grant=exec.
// STRUCTURE
//   bf8b_pkg: ARB_IDLE/GNT_F/GNT_E/DONE state localparams (2 bits),
//     GRANT_FETCH=2'b01 and GRANT_EXEC=2'b10.
//   Sub-module bus_watchdog: clear/enable/expire counter, parameter TIMEOUT,
//     tied off when TIMEOUT==0.
//   The starve counter and FSM stay inline.
// TESTING
//   1 f_req=1 addr=8'h10 alone, memory ready after 1 cycle
//     -> mem_req=1 addr=10 we=0; f_ready pulses once; rdata=mem_rdata=8'hA5.
//   2 f_req and e_req (we=1, addr=8'h80, wdata=8'h3C) rise in the same cycle
//     -> exec granted first with mem_we=1 and mem_wdata=3C; fetch granted after
//        DONE and IDLE.
//   3 e_req held continuously with f_req=1, STARVE_LIMIT=4
//     -> 4 exec grants, then 1 fetch grant, then exec resumes; with
//        STARVE_LIMIT=0 fetch is never granted.
//   4 exec read granted, mem_ready stuck low, TIMEOUT=64
//     -> after 64 grant cycles: mem_req=0, timeout and e_ready pulse together,
//        rdata unchanged, then IDLE.
//   5 rst asserted mid-GNT_E with mem_req=1
//     -> mem_req, grant and mem_we go to 0 with no clock edge; after release the
//        first grant behaves as from IDLE with starve=0.
//   6 e_addr changed and e_req dropped during GNT_E
//     -> mem_addr holds the latched value; e_ready still pulses on mem_ready.

Source files
------------

// File: rtl/bf8b_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_t  : arbiter FSM encoding (2 bits)
//   GRANT_FETCH  : one-hot grant code for the fetch stage
//   GRANT_EXEC   : one-hot grant code for the exec stage
package bf8b_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_F = 2'b01,
        ARB_GNT_E = 2'b10,
        ARB_DONE  = 2'b11
    } arb_state_t;

    localparam logic [1:0] GRANT_FETCH = 2'b01;
    localparam logic [1:0] GRANT_EXEC  = 2'b10;

endpackage

// File: rtl/bus_watchdog.sv
// Handshake watchdog for the memory bus arbiter.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clear     reload the timer (asserted on the edge that grants the bus)
//   enable    high while the arbiter sits in a grant state
//   expire    high when TIMEOUT grant cycles have passed since clear
// TIMEOUT == 0 removes the timer entirely; expire is then constant 0.
module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            // Down-counter loaded with TIMEOUT-1 at grant; the edge that sees
            // it at zero is the TIMEOUT-th edge spent in the grant state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= LOAD;
                end else if (enable && (cnt != '0)) begin
                    cnt <= cnt - CW'(1);
                end
            end

            assign expire = enable && (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single 8-bit memory bus shared by the fetch and exec stages.
// Exec has priority; fetch is guaranteed a grant after STARVE_LIMIT
// consecutive exec grants taken while it waited. All outputs are registered.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   f_req/f_addr/f_ready             fetch read port, f_ready pulses on done
//   e_req/e_we/e_addr/e_wdata/e_ready exec port, e_ready pulses on done
//   rdata                            read data captured at completion
//   grant                            one-hot owner {exec,fetch}
//   mem_req/mem_we/mem_addr/mem_wdata memory request side
//   mem_rdata/mem_ready              memory response side
//   timeout                          pulse on watchdog abort
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | bus free, arbitrate on requests at each edge
// ARB_GNT_F | fetch owns the bus, waiting for mem_ready or watchdog
// ARB_GNT_E | exec owns the bus, waiting for mem_ready or watchdog
// ARB_DONE  | one turnaround cycle, ready pulse high, grant still held
module mem_bus_arbiter
    import bf8b_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_ready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t        state, state_nxt;
    logic [SW-1:0]     starve, starve_nxt;
    logic [1:0]        grant_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, rdata_nxt;
    logic              f_ready_nxt, e_ready_nxt, timeout_nxt;
    logic              exec_wins;
    logic              wd_clear, wd_enable, wd_expire;

    assign wd_enable = (state == ARB_GNT_F) || (state == ARB_GNT_E);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Exec wins unless fetch is waiting and has already been passed over
    // STARVE_LIMIT times in a row.
    assign exec_wins = e_req &&
                       (!f_req || (starve < STARVE_MAX) || (STARVE_LIMIT == 0));

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve;
        grant_nxt     = grant;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rdata_nxt     = rdata;
        f_ready_nxt   = 1'b0;
        e_ready_nxt   = 1'b0;
        timeout_nxt   = 1'b0;
        wd_clear      = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (exec_wins) begin
                    state_nxt     = ARB_GNT_E;
                    grant_nxt     = GRANT_EXEC;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = e_we;
                    mem_addr_nxt  = e_addr;
                    mem_wdata_nxt = e_wdata;
                    wd_clear      = 1'b1;
                    if (!f_req) begin
                        starve_nxt = '0;
                    end else if (starve != STARVE_MAX) begin
                        starve_nxt = starve + SW'(1);
                    end
                end else if (f_req) begin
                    state_nxt     = ARB_GNT_F;
                    grant_nxt     = GRANT_FETCH;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = f_addr;
                    mem_wdata_nxt = '0;
                    wd_clear      = 1'b1;
                    starve_nxt    = '0;
                end
            end
            ARB_GNT_F, ARB_GNT_E: begin
                // A completing handshake takes precedence over a watchdog
                // expiring on the same edge.
                if (mem_ready || wd_expire) begin
                    state_nxt   = ARB_DONE;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    f_ready_nxt = (state == ARB_GNT_F);
                    e_ready_nxt = (state == ARB_GNT_E);
                    if (mem_ready) begin
                        if (!mem_we) begin
                            rdata_nxt = mem_rdata;
                        end
                    end else begin
                        timeout_nxt = 1'b1;
                    end
                end
            end
            ARB_DONE: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            starve    <= '0;
            grant     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            f_ready   <= 1'b0;
            e_ready   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            starve    <= starve_nxt;
            grant     <= grant_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rdata     <= rdata_nxt;
            f_ready   <= f_ready_nxt;
            e_ready   <= e_ready_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule
